uart_arbiter: RTL and testbench
===============================

// Module: uart_arbiter
// PURPOSE
//  Shares the single uart_tx byte transmitter between two byte-stream sources:
//  port 0 = mem2serial record stream, port 1 = status/overflow reporter.
//  Grants are frame-atomic: a granted source keeps the UART until it sends a byte
//  flagged last. Frames are scheduled round-robin.
//  A stalled frame is aborted after a timeout so one source cannot lock out the other.
//  Sits between the two sources and uart_tx, in the ext_clock domain.
// PARAMETERS
//  TIMEOUT  1024  cycles a granted source may hold valid low mid-frame before abort (>=2)
//  GUARD    2     max cycles to wait for uart_ready to drop after a strobe (>=1)
// PORTS
//  clock              in   1  system clock (ext_clock)
//  reset              in   1  synchronous reset, active-low
//  req0_valid         in   1  port 0 has a byte on req0_data
//  req0_data          in   8  port 0 byte
//  req0_last          in   1  byte is the last of port 0's frame
//  req0_ready         out  1  pop strobe to port 0 (combinational)
//  req1_valid/_data/_last/_ready   same as port 0, for port 1
//  uart_ready         in   1  uart_tx idle, can accept a byte
//  uart_data          out  8  byte to uart_tx
//  uart_clock_enable  out  1  one-cycle load strobe to uart_tx
//  grant              out  2  one-hot current owner, 00 = none
//  busy               out  1  state != IDLE
//  abort              out  1  one-cycle pulse on frame timeout
//  abort_count        out  8  saturating count of aborts (stays at 255)
// BEHAVIOUR
//  Reset (reset==0 at an edge): state IDLE; grant=00; uart_data=0x00;
//   uart_clock_enable=0; abort=0; abort_count=0; rr pointer=1, so port 0 wins first.
//   Reset mid-frame drops the grant, issues no strobe and pops nothing.
//  FSM states: IDLE, SEND, DRAIN.
//  IDLE:
//   - no valid: stay.
//   - one valid: grant that port, go SEND.
//   - both valid: grant the port != rr pointer.
//   - grant is registered, so it is visible the cycle after valid is seen.
//  SEND (owner g):
//   - reqg_ready = (state==SEND) & grant[g] & reqg_valid & uart_ready.
//   - on that edge: uart_data <= reqg_data; uart_clock_enable <= 1 for exactly one
//     cycle; latch reqg_last into last_q; clear timeout counter; go DRAIN.
//   - Latency from valid & uart_ready in SEND to strobe: 1 cycle.
//   - Non-owner ready is always 0. Non-owner valid is ignored mid-frame.
//  DRAIN:
//   - wait for uart_ready==0, or for GUARD cycles, whichever comes first.
//   - then if last_q: rr pointer <= g, grant <= 00, go IDLE; else go SEND.
//   - minimum spacing between strobes is therefore 2 cycles.
//  Timeout:
//   - counter runs in SEND while the owner's valid is low, and clears on each byte sent.
//   - counter reaching TIMEOUT-1: abort pulses for one cycle; abort_count += 1
//     unless already 255; rr pointer <= g; grant <= 00; go IDLE.
//   - the aborted frame is not resumed. The next byte from that port starts a new frame.
//  Rules:
//   - A source must hold data/last stable while valid is high and ready is low.
//   - uart_ready low in SEND stalls without counting toward the timeout.
//   - The counter counts only valid-low cycles.
//  Simultaneous events:
//   - timeout and a valid byte arriving on the same edge: the byte wins and no abort occurs.
//   - last byte of port A while port B is waiting: port B is granted 1 cycle after
//     returning to IDLE (IDLE->SEND).
// TESTING
//  1. Reset; port 0 sends 3-byte frame 0xA1,0xA2,0xA3(last), uart model drops ready
//     for 10 cycles per byte -> 3 strobes carrying those bytes in order;
//     grant 01 then 00; req0_ready exactly 3 single-cycle pulses.
//  2. Both ports valid from reset with 1-byte frames, continuously -> grant order
//     01,10,01,10; uart_data alternates between port bytes.
//  3. Port 1 raises valid after port 0's first byte of a 4-byte frame -> all 4
//     port 0 bytes are sent before any port 1 byte; req1_ready stays 0 until then.
//  4. TIMEOUT=16: port 0 sends 0x55 (not last) then drops valid -> abort pulse
//     16 cycles later; abort_count=1; grant 00; a pending port 1 frame is granted next.
//  5. uart_ready held high permanently -> strobes spaced GUARD+1 cycles apart; no hang.
//  6. Reset asserted in SEND mid-frame -> next cycle all outputs are at reset values;
//     after release port 0 is granted first; 256 forced aborts -> abort_count=255.

Source files
------------

// File: rtl/uart_arbiter.sv
// Frame-atomic round-robin arbiter sharing one uart_tx between two byte sources.
// A stalled owner is aborted after TIMEOUT valid-low cycles so the other source can proceed.
module uart_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int GUARD   = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       uart_ready,
   output logic [7:0] uart_data,
   output logic       uart_clock_enable,
   output logic [1:0] grant,
   output logic       busy,
   output logic       abort,
   output logic [7:0] abort_count
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   state_t          state, state_next;
   logic            rr_ptr;
   logic            last_q;
   logic [TW-1:0]   tcnt;
   logic [GW-1:0]   gcnt;

   logic            own_valid, own_last;
   logic [7:0]      own_data;
   logic            any_valid, pick1;
   logic            send, tmo_hit, drain_done;

   // Handshake: a byte moves on an edge where the owner's valid and ready are both high.
   // Ready is gated by reset so a reset edge never pops a source.
   always_comb begin
      own_valid  = grant[1] ? req1_valid : req0_valid;
      own_data   = grant[1] ? req1_data  : req0_data;
      own_last   = grant[1] ? req1_last  : req0_last;
      any_valid  = req0_valid | req1_valid;
      pick1      = req1_valid & (~req0_valid | ~rr_ptr);
      send       = reset & (state == SEND) & own_valid & uart_ready;
      tmo_hit    = (state == SEND) & ~own_valid & (tcnt == TW'(TIMEOUT - 1));
      drain_done = (state == DRAIN) & (~uart_ready | (gcnt == GW'(GUARD - 1)));
      req0_ready = send & grant[0];
      req1_ready = send & grant[1];
      busy       = (state != IDLE);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_valid) state_next = SEND;
         SEND: begin
            if (send)         state_next = DRAIN;
            else if (tmo_hit) state_next = IDLE;
         end
         DRAIN:   if (drain_done) state_next = last_q ? IDLE : SEND;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state             <= IDLE;
         grant             <= 2'b00;
         uart_data         <= 8'h00;
         uart_clock_enable <= 1'b0;
         abort             <= 1'b0;
         abort_count       <= 8'h00;
         rr_ptr            <= 1'b1;
         last_q            <= 1'b0;
         tcnt              <= '0;
         gcnt              <= '0;
      end else begin
         state             <= state_next;
         uart_clock_enable <= send;
         abort             <= tmo_hit;
         if (state == IDLE && any_valid) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            tcnt  <= '0;
         end
         if (send) begin
            uart_data <= own_data;
            last_q    <= own_last;
            tcnt      <= '0;
            gcnt      <= '0;
         end else if (state == SEND && !own_valid && !tmo_hit) begin
            tcnt <= tcnt + 1'b1;
         end
         if (state == DRAIN && !drain_done) gcnt <= gcnt + 1'b1;
         // End of frame, normal or aborted: release and remember who went last.
         if (tmo_hit || (drain_done && last_q)) begin
            grant  <= 2'b00;
            rr_ptr <= grant[1];
         end
         if (tmo_hit && abort_count != 8'hFF) abort_count <= abort_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: queue-fed source models, a uart_tx model, and a strobe monitor
// that checks every load against a queue of expected {grant, byte} entries.
module tb_uart_arbiter;

   localparam int TIMEOUT = 16;
   localparam int GUARD   = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic       uart_ready, uart_clock_enable, busy, abort;
   logic [7:0] uart_data, abort_count;
   logic [1:0] grant;

   uart_arbiter #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .uart_ready(uart_ready), .uart_data(uart_data), .uart_clock_enable(uart_clock_enable),
      .grant(grant), .busy(busy), .abort(abort), .abort_count(abort_count)
   );

   always #5 clock = ~clock;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [9:0] exp_q[$];
   logic [8:0] src0_q[$];
   logic [8:0] src1_q[$];
   int         gap_q[$];
   int         uart_hold = 0;
   int         ubusy = 0;
   int         cyc = 0, strobe_n = 0, strobe_cyc = -100, abort_n = 0, abort_cyc = 0;
   int         r0_high = 0, r0_rise = 0, own_viol = 0;
   logic       prev_ce = 1'b0, prev_abort = 1'b0, prev_r0 = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void drive();
      req0_valid = (src0_q.size() > 0);
      {req0_last, req0_data} = req0_valid ? src0_q[0] : 9'h000;
      req1_valid = (src1_q.size() > 0);
      {req1_last, req1_data} = req1_valid ? src1_q[0] : 9'h000;
      uart_ready = (ubusy == 0);
   endfunction

   task automatic push0(input logic last, input logic [7:0] data);
      src0_q.push_back({last, data});
      drive();
   endtask

   task automatic push1(input logic last, input logic [7:0] data);
      src1_q.push_back({last, data});
      drive();
   endtask

   task automatic expect_byte(input logic [1:0] g, input logic [7:0] d);
      exp_q.push_back({g, d});
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_drain(input int max);
      int k = 0;
      while ((exp_q.size() != 0 || busy || src0_q.size() != 0 || src1_q.size() != 0) && k < max) begin
         tick();
         k++;
      end
      chk("drain_pending_bytes", exp_q.size(), 0);
   endtask

   task automatic wait_strobe(input int target, input int max);
      int k = 0;
      while (strobe_n < target && k < max) begin
         tick();
         k++;
      end
      chk("strobe_wait", strobe_n, target);
   endtask

   task automatic wait_abort(input int max);
      int start = abort_n;
      int k = 0;
      while (abort_n == start && k < max) begin
         tick();
         k++;
      end
      chk("abort_wait", abort_n, start + 1);
   endtask

   // Source and uart_tx models: sample handshakes at the edge, update 1 time unit later.
   initial begin : drivers
      logic p0, p1, st;
      forever begin
         @(posedge clock);
         p0 = req0_ready;
         p1 = req1_ready;
         st = uart_clock_enable;
         #1;
         if (p0 && src0_q.size() > 0) void'(src0_q.pop_front());
         if (p1 && src1_q.size() > 0) void'(src1_q.pop_front());
         if (st && uart_hold > 0) ubusy = uart_hold;
         else if (ubusy > 0) ubusy--;
         drive();
      end
   end

   // Monitor: scoreboard on strobes, pulse widths, and ownership of ready.
   initial begin : monitor
      logic [9:0] e;
      forever begin
         @(negedge clock);
         cyc++;
         if (req0_ready === 1'b1 && grant !== 2'b01) own_viol++;
         if (req1_ready === 1'b1 && grant !== 2'b10) own_viol++;
         if (req0_ready === 1'b1) begin
            r0_high++;
            if (!prev_r0) r0_rise++;
         end
         prev_r0 = (req0_ready === 1'b1);
         if (uart_clock_enable === 1'b1) begin
            chk("strobe_width", int'(prev_ce), 0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_strobe: grant=%b data=%h, no strobe expected", grant, uart_data);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_grant_data", int'({grant, uart_data}), int'(e));
            end
            gap_q.push_back(cyc - strobe_cyc);
            strobe_cyc = cyc;
            strobe_n++;
         end
         prev_ce = (uart_clock_enable === 1'b1);
         if (abort === 1'b1) begin
            chk("abort_width", int'(prev_abort), 0);
            chk("abort_grant", int'(grant), 0);
            abort_n++;
            abort_cyc = cyc;
         end
         prev_abort = (abort === 1'b1);
      end
   end

   initial begin : stimulus
      int s, n;
      reset = 1'b0;
      drive();

      // Reset state, with both ports already holding 1-byte frames.
      push0(1'b1, 8'h10); push0(1'b1, 8'h11);
      push1(1'b1, 8'h20); push1(1'b1, 8'h21);
      tick(); tick();
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_uart_data", int'(uart_data), 0);
      chk("rst_strobe", int'(uart_clock_enable), 0);
      chk("rst_abort", int'(abort), 0);
      chk("rst_abort_count", int'(abort_count), 0);
      chk("rst_req0_ready", int'(req0_ready), 0);

      // Both ports contending: port 0 first, then strict alternation.
      expect_byte(2'b01, 8'h10); expect_byte(2'b10, 8'h20);
      expect_byte(2'b01, 8'h11); expect_byte(2'b10, 8'h21);
      @(negedge clock);
      reset = 1'b1;
      wait_drain(200);

      // Single 3-byte frame with a slow uart.
      uart_hold = 10;
      r0_high = 0;
      r0_rise = 0;
      push0(1'b0, 8'hA1); push0(1'b0, 8'hA2); push0(1'b1, 8'hA3);
      expect_byte(2'b01, 8'hA1); expect_byte(2'b01, 8'hA2); expect_byte(2'b01, 8'hA3);
      tick();
      chk("t1_grant_owner", int'(grant), 1);
      wait_drain(300);
      chk("t1_grant_released", int'(grant), 0);
      chk("t1_ready_cycles", r0_high, 3);
      chk("t1_ready_pulses", r0_rise, 3);

      // Port 1 arrives mid-frame and must wait for port 0's last byte.
      uart_hold = 3;
      push0(1'b0, 8'hC0); push0(1'b0, 8'hC1); push0(1'b0, 8'hC2); push0(1'b1, 8'hC3);
      expect_byte(2'b01, 8'hC0); expect_byte(2'b01, 8'hC1);
      expect_byte(2'b01, 8'hC2); expect_byte(2'b01, 8'hC3);
      expect_byte(2'b10, 8'hD0);
      wait_strobe(strobe_n + 1, 50);
      push1(1'b1, 8'hD0);
      wait_drain(300);

      // Timeout: the strobe is followed by 2 DRAIN edges, then 16 valid-low SEND edges.
      uart_hold = 0;
      push0(1'b0, 8'h55);
      expect_byte(2'b01, 8'h55);
      expect_byte(2'b10, 8'h77);
      wait_strobe(strobe_n + 1, 50);
      s = strobe_cyc;
      push1(1'b1, 8'h77);
      wait_abort(40);
      chk("t4_abort_latency", abort_cyc - s, 2 + TIMEOUT);
      chk("t4_abort_count", int'(abort_count), 1);
      wait_drain(100);

      // Permanently ready uart: strobes GUARD+1 cycles apart.
      gap_q.delete();
      push0(1'b0, 8'hE0); push0(1'b0, 8'hE1); push0(1'b0, 8'hE2); push0(1'b1, 8'hE3);
      expect_byte(2'b01, 8'hE0); expect_byte(2'b01, 8'hE1);
      expect_byte(2'b01, 8'hE2); expect_byte(2'b01, 8'hE3);
      wait_drain(200);
      chk("t5_strobes", gap_q.size(), 4);
      for (int i = 1; i < 4 && i < gap_q.size(); i++) chk("t5_gap", gap_q[i], GUARD + 1);

      // Reset while the owner is stalled in SEND.
      uart_hold = 10;
      push0(1'b0, 8'hB0); push0(1'b0, 8'hB1); push0(1'b1, 8'hB2);
      expect_byte(2'b01, 8'hB0);
      wait_strobe(strobe_n + 1, 50);
      repeat (4) tick();
      reset = 1'b0;
      ubusy = 0;
      uart_hold = 0;
      drive();
      #1;
      chk("t6_ready_in_reset", int'(req0_ready), 0);
      n = src0_q.size();
      tick();
      chk("t6_no_pop_in_reset", src0_q.size(), 2);
      chk("t6_rst_grant", int'(grant), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_uart_data", int'(uart_data), 0);
      chk("t6_rst_strobe", int'(uart_clock_enable), 0);
      chk("t6_rst_abort", int'(abort), 0);
      chk("t6_rst_abort_count", int'(abort_count), 0);
      if (n != 2) $display("note: %0d bytes were queued at reset", n);
      src0_q.delete();
      src1_q.delete();
      exp_q.delete();
      drive();
      tick();
      reset = 1'b1;
      push0(1'b1, 8'h30);
      push1(1'b1, 8'h40);
      expect_byte(2'b01, 8'h30); expect_byte(2'b10, 8'h40);
      wait_drain(100);

      // 256 aborted single-byte frames: the counter saturates at 255.
      for (int i = 0; i < 256; i++) begin
         push0(1'b0, 8'(i));
         expect_byte(2'b01, 8'(i));
         wait_abort(40);
         if (i == 99) chk("t6_abort_count_100", int'(abort_count), 100);
         if (i == 254) chk("t6_abort_count_255", int'(abort_count), 255);
      end
      tick();
      chk("t6_abort_count_sat", int'(abort_count), 255);
      chk("t6_exp_empty", exp_q.size(), 0);
      chk("ownership_violations", own_viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
